// File: rtl/fix_conv_pkg.sv
// Shared definitions for the fixed-point converter scheduler: FSM states and
// IEEE-754 single-precision field constants.
package fix_conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_RESP = 2'd2
    } conv_state_t;

    localparam int FP_BIAS   = 127;
    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;

    function automatic logic [FP_EXP_W-1:0] fp_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

endpackage

// File: rtl/single_to_fix_core.sv
// Combinational IEEE-754 single to unsigned fixed-point converter; magnitude is
// truncated and wraps modulo 2^(INT_WIDTH+FRACT_WIDTH).
module single_to_fix_core
    import fix_conv_pkg::*;
#(
    parameter int INT_WIDTH   = 12,
    parameter int FRACT_WIDTH = 4
) (
    input  logic [31:0]                      fp_in,
    output logic [INT_WIDTH+FRACT_WIDTH-1:0] fix_out
);

    localparam int W         = INT_WIDTH + FRACT_WIDTH;
    localparam int SHIFT_OFS = FP_BIAS + FP_MANT_W - FRACT_WIDTH;

    logic [FP_EXP_W-1:0]    exp_s;
    logic [FP_MANT_W:0]     mant_s;
    logic [FP_MANT_W+W:0]   wide_s;
    logic signed [9:0]      sh_s;
    logic [9:0]             lsh_s;
    logic [9:0]             rsh_s;
    logic                   unused_sign_s;

    assign unused_sign_s = fp_in[31];

    // Barrel shift of the restored mantissa by (exponent - bias - mantissa bits + FRACT_WIDTH)
    always_comb begin
        exp_s   = fp_exp(fp_in);
        mant_s  = {1'b1, fp_in[FP_MANT_W-1:0]};
        sh_s    = $signed({2'b00, exp_s}) - $signed(10'(SHIFT_OFS));
        lsh_s   = $unsigned(sh_s);
        rsh_s   = $unsigned(-sh_s);
        wide_s  = '0;
        fix_out = '0;
        if (exp_s == 8'h00 || exp_s == 8'hFF) begin
            fix_out = '0;
        end else if (!sh_s[9]) begin
            if (lsh_s >= 10'(W)) begin
                fix_out = '0;
            end else begin
                wide_s  = {{W{1'b0}}, mant_s} << lsh_s;
                fix_out = wide_s[W-1:0];
            end
        end else begin
            if (rsh_s >= 10'(FP_MANT_W + 1)) begin
                fix_out = '0;
            end else begin
                wide_s  = {{W{1'b0}}, mant_s} >> rsh_s;
                fix_out = wide_s[W-1:0];
            end
        end
    end

endmodule

// File: rtl/fix_conv_sched.sv
// Round-robin scheduler sharing one single-to-fixed converter among NUM_REQ requesters.
// Optional saturation of out-of-range operands is enabled with FIX_CONV_SAT_EN.
module fix_conv_sched
    import fix_conv_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int INT_WIDTH   = 12,
    parameter int FRACT_WIDTH = 4,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [NUM_REQ-1:0]               i_req_valid,
    input  logic [32*NUM_REQ-1:0]            i_req_data,
    output logic [NUM_REQ-1:0]               o_req_ready,
    output logic                             o_rsp_valid,
    input  logic                             i_rsp_ready,
    output logic [INT_WIDTH+FRACT_WIDTH-1:0] o_rsp_data,
    output logic [ID_W-1:0]                  o_rsp_id,
    output logic                             o_rsp_sat
);

    localparam int W = INT_WIDTH + FRACT_WIDTH;

    conv_state_t        state_r;
    logic [ID_W-1:0]    last_r;
    logic [ID_W-1:0]    id_r;
    logic [31:0]        op_r;
    logic [W-1:0]       core_out_s;
    logic [ID_W:0]      cand_s;
    logic [ID_W-1:0]    win_s;
    logic               found_s;
    logic [NUM_REQ-1:0] grant_s;

    single_to_fix_core #(
        .INT_WIDTH   (INT_WIDTH),
        .FRACT_WIDTH (FRACT_WIDTH)
    ) u_core (
        .fp_in   (op_r),
        .fix_out (core_out_s)
    );

    // Round-robin search starting one past the last winner
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        cand_s  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_s = {1'b0, last_r} + (ID_W+1)'(i);
            if (cand_s >= (ID_W+1)'(NUM_REQ)) begin
                cand_s = cand_s - (ID_W+1)'(NUM_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && i_req_valid[cand_s[ID_W-1:0]]) begin
                found_s = 1'b1;
                win_s   = cand_s[ID_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // One-hot accept, only ever offered while idle
    always_comb begin
        grant_s = '0;
        if (state_r == ST_IDLE && found_s) begin
            grant_s[win_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    assign o_req_ready = grant_s;

`ifdef FIX_CONV_SAT_EN
    logic sat_hit_s;
    logic sat_r;

    // Saturation is decided from the exponent alone, ahead of the result register
    always_comb begin
        sat_hit_s = 1'b0;
        if (fp_exp(op_r) >= 8'(FP_BIAS + INT_WIDTH)) begin
            sat_hit_s = 1'b1;
        end else begin
            sat_hit_s = 1'b0;
        end
    end

    assign o_rsp_sat = sat_r;
`else
    assign o_rsp_sat = 1'b0;
`endif

    // Scheduler FSM: capture winner, convert, hold response until accepted
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r     <= ST_IDLE;
            last_r      <= ID_W'(NUM_REQ - 1);
            id_r        <= '0;
            op_r        <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_rsp_id    <= '0;
`ifdef FIX_CONV_SAT_EN
            sat_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        op_r    <= i_req_data[32*win_s +: 32];
                        id_r    <= win_s;
                        last_r  <= win_s;
                        state_r <= ST_CONV;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CONV: begin
`ifdef FIX_CONV_SAT_EN
                    o_rsp_data <= sat_hit_s ? {W{1'b1}} : core_out_s;
                    sat_r      <= sat_hit_s;
`else
                    o_rsp_data <= core_out_s;
`endif
                    o_rsp_id    <= id_r;
                    o_rsp_valid <= 1'b1;
                    state_r     <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_RESP;
                    end
                end
                default: begin
                    o_rsp_valid <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fix_conv_sched.sv
// Directed self-checking bench for fix_conv_sched (NUM_REQ=4, 12.4 format).
module tb_fix_conv_sched;

    localparam int NUM_REQ = 4;
    localparam int INT_W   = 12;
    localparam int FRAC_W  = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [15:0]  rsp_data;
    logic [1:0]   rsp_id;
    logic         rsp_sat;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fix_conv_sched #(
        .NUM_REQ     (NUM_REQ),
        .INT_WIDTH   (INT_W),
        .FRACT_WIDTH (FRAC_W)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_rsp_id    (rsp_id),
        .o_rsp_sat   (rsp_sat)
    );

    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_data  = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_data  = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %0b want 0", rsp_valid); end
        tests_run++; if (rsp_data !== 16'h0000) begin tests_failed++; $display("FAIL reset_data got %h want 0000", rsp_data); end
        tests_run++; if (rsp_id !== 2'd0) begin tests_failed++; $display("FAIL reset_id got %0d want 0", rsp_id); end
        tests_run++; if (rsp_sat !== 1'b0) begin tests_failed++; $display("FAIL reset_sat got %0b want 0", rsp_sat); end
        rst = 1'b0;
        @(negedge clk);
        tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL idle_valid got %0b want 0", rsp_valid); end
    endtask

    task automatic test_single();
        int lat;
        @(negedge clk);
        req_valid      = 4'b0001;
        req_data[31:0] = 32'h3F800000;
        #1;
        tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL single_grant got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL single_latency got %0d want 2", lat); end
        tests_run++; if (rsp_data !== 16'h0010) begin tests_failed++; $display("FAIL single_data got %h want 0010", rsp_data); end
        tests_run++; if (rsp_id !== 2'd0) begin tests_failed++; $display("FAIL single_id got %0d want 0", rsp_id); end
        @(negedge clk);
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL single_drop got %0b want 0", rsp_valid); end
    endtask

    task automatic test_values();
        logic [31:0] vin  [5] = '{32'h40200000, 32'hC0400000, 32'h3D000000, 32'h00000001, 32'h3FC00000};
        logic [15:0] vexp [5] = '{16'h0028, 16'h0030, 16'h0000, 16'h0000, 16'h0018};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid      = 4'b0001;
            req_data[31:0] = vin[i];
            #1;
            tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL value_grant[%0d] got %b want 0001", i, req_ready); end
            @(negedge clk);
            req_valid = 4'b0000;
            @(negedge clk);
            tests_run++; if (rsp_valid !== 1'b1 || rsp_data !== vexp[i]) begin tests_failed++; $display("FAIL value[%0d] in %h got v=%0b d=%h want v=1 d=%h", i, vin[i], rsp_valid, rsp_data, vexp[i]); end
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] rexp [4] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
        apply_reset();
        req_data  = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            #1;
            tests_run++; if (req_ready !== (4'b0001 << (g % 4))) begin tests_failed++; $display("FAIL rr_grant[%0d] got %b want %b", g, req_ready, 4'b0001 << (g % 4)); end
            @(negedge clk);
            tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL rr_conv_ready[%0d] got %b want 0000", g, req_ready); end
            @(negedge clk);
            tests_run++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(g % 4) || rsp_data !== rexp[g % 4]) begin
                tests_failed++; $display("FAIL rr_rsp[%0d] got v=%0b id=%0d d=%h want v=1 id=%0d d=%h", g, rsp_valid, rsp_id, rsp_data, g % 4, rexp[g % 4]);
            end
            @(negedge clk);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        rsp_ready        = 1'b0;
        req_data[63:32]  = 32'h40200000;
        req_data[95:64]  = 32'hC0400000;
        req_valid        = 4'b0110;
        #1;
        tests_run++; if (req_ready !== 4'b0010) begin tests_failed++; $display("FAIL bp_grant1 got %b want 0010", req_ready); end
        @(negedge clk);
        req_valid = 4'b0100;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            tests_run++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0028 || rsp_id !== 2'd1 || req_ready !== 4'b0000) begin
                tests_failed++; $display("FAIL bp_hold[%0d] got v=%0b d=%h id=%0d rdy=%b want v=1 d=0028 id=1 rdy=0000", c, rsp_valid, rsp_data, rsp_id, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        tests_run++; if (req_ready !== 4'b0100 || rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_regrant got rdy=%b v=%0b want rdy=0100 v=0", req_ready, rsp_valid); end
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        tests_run++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0030 || rsp_id !== 2'd2) begin tests_failed++; $display("FAIL bp_rsp2 got v=%0b d=%h id=%0d want v=1 d=0030 id=2", rsp_valid, rsp_data, rsp_id); end
    endtask

    task automatic test_overflow();
        logic [31:0] oin [2] = '{32'h459C4000, 32'h7F800000};
`ifdef FIX_CONV_SAT_EN
        logic [15:0] oexp [2] = '{16'hFFFF, 16'hFFFF};
        logic        osat [2] = '{1'b1, 1'b1};
`else
        logic [15:0] oexp [2] = '{16'h3880, 16'h0000};
        logic        osat [2] = '{1'b0, 1'b0};
`endif
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            req_valid         = 4'b1000;
            req_data[127:96]  = oin[i];
            #1;
            tests_run++; if (req_ready !== 4'b1000) begin tests_failed++; $display("FAIL ovf_grant[%0d] got %b want 1000", i, req_ready); end
            @(negedge clk);
            req_valid = 4'b0000;
            @(negedge clk);
            tests_run++; if (rsp_data !== oexp[i] || rsp_sat !== osat[i] || rsp_id !== 2'd3) begin
                tests_failed++; $display("FAIL ovf[%0d] in %h got d=%h sat=%0b id=%0d want d=%h sat=%0b id=3", i, oin[i], rsp_data, rsp_sat, rsp_id, oexp[i], osat[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid      = 4'b0001;
        req_data[31:0] = 32'h3F800000;
        #1;
        tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL rmid_grant got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        rst       = 1'b1;
        #1;
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rmid_valid got %0b want 0", rsp_valid); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++; if (rsp_valid !== 1'b0 || rsp_data !== 16'h0000) begin tests_failed++; $display("FAIL rmid_after got v=%0b d=%h want v=0 d=0000", rsp_valid, rsp_data); end
        req_data[63:32] = 32'h40000000;
        req_valid       = 4'b0011;
        #1;
        tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL rmid_first got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        tests_run++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0010 || rsp_id !== 2'd0) begin tests_failed++; $display("FAIL rmid_rsp got v=%0b d=%h id=%0d want v=1 d=0010 id=0", rsp_valid, rsp_data, rsp_id); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_values();
        test_round_robin();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
